// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: sequences one register-file access per request.
// It reads two operands, optionally writes one register, then holds the
// operands until the consumer takes them.
//
// Optional feature: define RF_WRITE_FIRST_EN to perform the write before
// the operand read when wen=1, so operands that name rd see the new data.
//
// state | meaning
// IDLE  | ready for a request
// READ  | read addresses driven, operands captured at end of cycle
// WRITE | single-cycle register-file write strobe
// HOLD  | operands presented, waiting for op_ready
module rf_access_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_rs,
    input  logic [ADDR_W-1:0]    req_rt,
    input  logic [ADDR_W-1:0]    req_rd,
    input  logic                 req_wen,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic [ADDR_W-1:0]    rf_addr1,
    output logic [ADDR_W-1:0]    rf_addr2,
    input  logic [WORD_SIZE-1:0] rf_data1,
    input  logic [WORD_SIZE-1:0] rf_data2,
    output logic [ADDR_W-1:0]    rf_addr3,
    output logic [WORD_SIZE-1:0] rf_data3,
    output logic                 rf_write,
    output logic                 op_valid,
    output logic [WORD_SIZE-1:0] op_a,
    output logic [WORD_SIZE-1:0] op_b,
    input  logic                 op_ready
);

`ifdef RF_WRITE_FIRST_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  wen_q;
    logic                  req_ready_q;
    logic                  op_valid_q;
    logic                  rf_write_q;
    logic [ADDR_W-1:0]     rf_addr1_q, rf_addr2_q, rf_addr3_q;
    logic [WORD_SIZE-1:0]  rf_data3_q;
    logic [WORD_SIZE-1:0]  op_a_q, op_b_q;

    // Next-state selection; write-first order only changes the wen=1 path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (req_wen && WRITE_FIRST) ? WRITE : READ;
            READ:    state_d = (wen_q && !WRITE_FIRST) ? WRITE : HOLD;
            WRITE:   state_d = WRITE_FIRST ? READ : HOLD;
            HOLD:    if (op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wen_q       <= 1'b0;
            req_ready_q <= 1'b1;
            op_valid_q  <= 1'b0;
            rf_write_q  <= 1'b0;
            rf_addr1_q  <= '0;
            rf_addr2_q  <= '0;
            rf_addr3_q  <= '0;
            rf_data3_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == IDLE);
            op_valid_q  <= (state_d == HOLD);
            rf_write_q  <= (state_d == WRITE);
            if (state_q == IDLE && req_valid) begin
                wen_q      <= req_wen;
                rf_addr1_q <= req_rs;
                rf_addr2_q <= req_rt;
                // Write port only moves when a write is requested, so it keeps its last value otherwise.
                if (req_wen) begin
                    rf_addr3_q <= req_rd;
                    rf_data3_q <= req_wdata;
                end
            end
            if (state_q == READ) begin
                op_a_q <= rf_data1;
                op_b_q <= rf_data2;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign rf_addr1  = rf_addr1_q;
    assign rf_addr2  = rf_addr2_q;
    assign rf_addr3  = rf_addr3_q;
    assign rf_data3  = rf_data3_q;
    // Gate the strobe with reset so a reset landing mid-WRITE cannot commit the write.
    assign rf_write  = rf_write_q & ~reset;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a 4-entry register-file model.
module tb_rf_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [1:0]  req_rs, req_rt, req_rd;
    logic        req_wen;
    logic [15:0] req_wdata;
    logic [1:0]  rf_addr1, rf_addr2, rf_addr3;
    logic [15:0] rf_data1, rf_data2, rf_data3;
    logic        rf_write;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b;

    logic        pre_we;
    logic [1:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem [4];
    logic [15:0] init_val [4];

    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_prev = 0;

    rf_access_ctrl #(.WORD_SIZE(16), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_wen(req_wen), .req_wdata(req_wdata),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .rf_addr3(rf_addr3), .rf_data3(rf_data3), .rf_write(rf_write),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready)
    );

    always #5 clk = ~clk;

    assign rf_data1 = mem[rf_addr1];
    assign rf_data2 = mem[rf_addr2];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (rf_write) mem[rf_addr3] <= rf_data3;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && !reset) begin
            acc_prev <= acc_cyc;
            acc_cyc  <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                             input logic wen, input logic [15:0] wd);
        req_valid = 1'b1;
        req_rs = rs; req_rt = rt; req_rd = rd; req_wen = wen; req_wdata = wd;
    endtask

    initial begin
        init_val[0] = 16'h7777; init_val[1] = 16'h1234;
        init_val[2] = 16'hABCD; init_val[3] = 16'h5555;
        reset = 1'b1; req_valid = 1'b0; req_rs = 0; req_rt = 0; req_rd = 0;
        req_wen = 1'b0; req_wdata = 0; op_ready = 1'b0;
        pre_we = 1'b0; pre_addr = 0; pre_data = 0;

        // Preload the file model while the block is held in reset.
        tick();
        for (int i = 0; i < 4; i++) begin
            pre_we = 1'b1; pre_addr = 2'(i); pre_data = init_val[i];
            tick();
        end
        pre_we = 1'b0;
        check("rst_rf_write", rf_write, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_op_valid", op_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_addr1", rf_addr1, 0);
        check("rst_addr2", rf_addr2, 0);
        check("rst_addr3", rf_addr3, 0);
        check("rst_data3", rf_data3, 0);
        reset = 1'b0;
        tick();
        check("idle_ready", req_ready, 1);

        // Plain read: rs=1, rt=2, wen=0.
        drive_req(2'd1, 2'd2, 2'd0, 1'b0, 16'h0000);
        op_ready = 1'b1;
        tick();
        check("s1_read_ready", req_ready, 0);
        check("s1_read_addr1", rf_addr1, 1);
        check("s1_read_addr2", rf_addr2, 2);
        check("s1_read_wr", rf_write, 0);
        check("s1_read_opv", op_valid, 0);
        req_valid = 1'b0;
        tick();
        check("s1_opv", op_valid, 1);
        check("s1_op_a", op_a, 16'h1234);
        check("s1_op_b", op_b, 16'hABCD);
        check("s1_hold_wr", rf_write, 0);
        tick();
        check("s1_back_idle", req_ready, 1);
        check("s1_opv_low", op_valid, 0);

        // rs=rt=rd=3 with a write of 0x00FF over r3=0x5555.
        drive_req(2'd3, 2'd3, 2'd3, 1'b1, 16'h00FF);
        op_ready = 1'b0;
        tick();
        req_valid = 1'b0;
`ifdef RF_WRITE_FIRST_EN
        check("s2_wr_strobe", rf_write, 1);
        check("s2_wr_addr3", rf_addr3, 3);
        check("s2_wr_data3", rf_data3, 16'h00FF);
        tick();
        check("s2_rd_nostrobe", rf_write, 0);
        check("s2_rd_addr1", rf_addr1, 3);
        tick();
        check("s2_opv", op_valid, 1);
        check("s2_op_a", op_a, 16'h00FF);
        check("s2_op_b", op_b, 16'h00FF);
`else
        check("s2_rd_nostrobe", rf_write, 0);
        check("s2_rd_addr1", rf_addr1, 3);
        tick();
        check("s2_wr_strobe", rf_write, 1);
        check("s2_wr_addr3", rf_addr3, 3);
        check("s2_wr_data3", rf_data3, 16'h00FF);
        check("s2_wr_opv", op_valid, 0);
        tick();
        check("s2_opv", op_valid, 1);
        check("s2_op_a", op_a, 16'h5555);
        check("s2_op_b", op_b, 16'h5555);
`endif
        check("s2_hold_wr", rf_write, 0);
        check("s2_r3_written", mem[3], 16'h00FF);
        op_ready = 1'b1;
        tick();
        check("s2_back_idle", req_ready, 1);

        // HOLD with op_ready low for 5 cycles while another request waits.
        drive_req(2'd0, 2'd1, 2'd0, 1'b0, 16'h0000);
        op_ready = 1'b0;
        tick();
        drive_req(2'd2, 2'd2, 2'd0, 1'b0, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("s3_hold_opv", op_valid, 1);
            check("s3_hold_op_a", op_a, 16'h7777);
            check("s3_hold_op_b", op_b, 16'h1234);
            check("s3_hold_noacc", req_ready, 0);
        end
        op_ready = 1'b1;
        tick();
        check("s3_idle_ready", req_ready, 1);
        check("s3_idle_opv", op_valid, 0);
        tick();
        check("s3_accepted", req_ready, 0);
        check("s3_new_addr1", rf_addr1, 2);
        req_valid = 1'b0;
        tick();
        check("s3_same_a", op_a, 16'hABCD);
        check("s3_same_b", op_b, 16'hABCD);
        tick();

        // Reset landing in WRITE, with a request offered during reset.
        drive_req(2'd1, 2'd2, 2'd0, 1'b1, 16'hBEEF);
        op_ready = 1'b1;
        tick();
`ifndef RF_WRITE_FIRST_EN
        tick();
`endif
        reset = 1'b1;
        drive_req(2'd1, 2'd1, 2'd0, 1'b0, 16'h0000);
        #1;
        check("s4_wr_gated", rf_write, 0);
        tick();
        check("s4_r0_kept", mem[0], 16'h7777);
        check("s4_rst_ready", req_ready, 1);
        check("s4_rst_opv", op_valid, 0);
        check("s4_rst_wr", rf_write, 0);
        tick();
        check("s4_noacc_in_rst", req_ready, 1);
        reset = 1'b0;
        req_valid = 1'b0;
        tick();
        check("s4_idle_after", req_ready, 1);

        // Back-to-back: write r1=0x0001, then read rs=1.
        drive_req(2'd0, 2'd0, 2'd1, 1'b1, 16'h0001);
        tick();
        drive_req(2'd1, 2'd1, 2'd0, 1'b0, 16'h0000);
        tick();
        tick();
        tick();
        tick();
        req_valid = 1'b0;
        check("s5_spacing", 32'(acc_cyc - acc_prev), 4);
        tick();
        check("s5_opv", op_valid, 1);
        check("s5_op_a", op_a, 16'h0001);
        check("s5_r1_mem", mem[1], 16'h0001);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, the datapath word width.
REQ-002 The block SHALL have parameter ADDR_W, default 2, the register address width (4 registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: an access request is offered.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have ports req_rs and req_rt, input, ADDR_W each: source register addresses.
REQ-008 The block SHALL have port req_rd, input, ADDR_W: destination register address.
REQ-009 The block SHALL have port req_wen, input, 1 bit: the request includes a register write.
REQ-010 The block SHALL have port req_wdata, input, WORD_SIZE: the write data.
REQ-011 The block SHALL have ports rf_addr1 and rf_addr2, output, ADDR_W each: register-file read addresses.
REQ-012 The block SHALL have ports rf_data1 and rf_data2, input, WORD_SIZE each: register-file combinational read data.
REQ-013 The block SHALL have ports rf_addr3 (output, ADDR_W), rf_data3 (output, WORD_SIZE) and rf_write (output, 1 bit): the register-file write port, sampled by the file on rising clk.
REQ-014 The block SHALL have ports op_valid (output, 1 bit), op_a and op_b (output, WORD_SIZE each) and op_ready (input, 1 bit): the operand result handshake.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, WRITE and HOLD.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on the edge where req_ready and req_valid are both 1; rs, rt, rd, wen and wdata SHALL be latched internally, and the FSM SHALL go from IDLE to READ.
REQ-018 In READ, rf_addr1 and rf_addr2 SHALL be driven with the latched rs and rt; at the end of the READ cycle, rf_data1 and rf_data2 SHALL be captured into op_a and op_b.
REQ-019 From READ, the FSM SHALL go to WRITE if wen=1, otherwise to HOLD.
REQ-020 In WRITE, for exactly one cycle, rf_write SHALL be 1, rf_addr3 SHALL be rd and rf_data3 SHALL be wdata; the FSM SHALL then go to HOLD.
REQ-021 rf_write SHALL be 0 in every state other than WRITE, and SHALL also be 0 in any cycle where reset=1.
REQ-022 In HOLD, op_valid SHALL be 1 and op_a and op_b SHALL be stable; the FSM SHALL go to IDLE on the edge where op_ready=1.
REQ-023 When op_ready=0, HOLD SHALL persist indefinitely.
REQ-024 In HOLD, req_valid SHALL be ignored; a new request is accepted only after returning to IDLE.
REQ-025 Latency from acceptance to op_valid SHALL be 2 cycles when wen=0 and 3 cycles when wen=1.
REQ-026 Minimum request spacing SHALL be 3 cycles (wen=0) or 4 cycles (wen=1), with op_ready tied high.
REQ-027 When rs==rt, both operands SHALL carry the same register value.
REQ-028 When rs or rt equals rd, the operands SHALL carry the pre-write value (default build).
REQ-029 When not in READ, rf_addr1, rf_addr2 and rf_addr3 SHALL hold their last driven values; they are don't-care to the file.

Reset
REQ-030 When reset=1 at a rising edge, the FSM SHALL go to IDLE from any state, including mid-WRITE and mid-HOLD, and the in-flight request SHALL be discarded.
REQ-031 After reset: req_ready=1, op_valid=0, op_a=0, op_b=0, rf_write=0, and rf_addr1, rf_addr2, rf_addr3 and rf_data3 SHALL be 0.
REQ-032 A request presented while reset=1 SHALL NOT be accepted.

Configuration
REQ-033 Macro RF_WRITE_FIRST_EN: when defined, the order SHALL be IDLE->WRITE->READ->HOLD when wen=1 (wen=0 SHALL be unchanged), so operands reading rd return the new wdata; latency is unchanged at 3 cycles.
REQ-034 When RF_WRITE_FIRST_EN is undefined, the order SHALL be READ before WRITE as in REQ-018 to REQ-020.

Verification
REQ-035 Scenario: after reset, the file holds r1=0x1234, r2=0xABCD; request rs=1, rt=2, wen=0 -> op_valid 2 cycles after acceptance with op_a=0x1234, op_b=0xABCD, and rf_write never 1.
REQ-036 Scenario: request rs=3, rt=3, rd=3, wen=1, wdata=0x00FF, with r3=0x5555 -> default build gives op_a=op_b=0x5555, then r3=0x00FF; with RF_WRITE_FIRST_EN, op_a=op_b=0x00FF.
REQ-037 Scenario: op_ready held 0 for 5 cycles in HOLD -> op_valid and operands stable; req_valid=1 is not accepted; acceptance occurs in the cycle after op_ready rises.
REQ-038 Scenario: reset asserted during WRITE (wen=1, rd=0, wdata=0xBEEF) -> rf_write=0 on that edge; r0 is unchanged; the next cycle is IDLE with req_ready=1 and op_valid=0.
REQ-039 Scenario: back-to-back requests with op_ready=1 (write r1=0x0001, then read rs=1) -> the second request sees op_a=0x0001; acceptance spacing is exactly 4 cycles.
